rx_read_scheduler: RTL and testbench
====================================

Name: rx_read_scheduler

Overview:
- Credit-based scheduler between the TCP stack notification stream and the read-package request channel.
- Issues a read request only when the downstream payload buffer has room for the whole message, counted in 64-byte beats.
- Forwards the 88-bit notification as metadata to the merge stage when the request is issued.
- Drops zero-length, oversize and (optionally) unaligned messages, and counts each drop.

Parameters:
BUF_BEATS, 32, payload buffer depth in 512-bit beats; initial and maximum credit.
MAX_LEN, 4096, largest accepted message length in bytes.
ALIGN_ONLY, 1, when 1, also drop messages whose length is not a multiple of 64.
CNT_W, 32, drop counter width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_axis_notifications_TDATA  in  88  [15:0] session, [31:16] length in bytes, [87:32] opaque
s_axis_notifications_TVALID  in  1  notification valid
s_axis_notifications_TREADY  out  1  notification accept
m_axis_read_package_TDATA  out  32  {length, session}
m_axis_read_package_TVALID  out  1  read request valid
m_axis_read_package_TREADY  in  1  read request accept
m_axis_meta_TDATA  out  88  notification copy
m_axis_meta_TVALID  out  1  metadata valid
m_axis_meta_TREADY  in  1  metadata accept
credit_ret  in  1  one pulse per payload beat drained from the buffer
credits  out  clog2(BUF_BEATS+1)  current free beats
drop_cnt  out  CNT_W  dropped notifications, saturating
credit_err  out  1  sticky; a return arrived with credits == BUF_BEATS

Behaviour:
- Clocking: single clock domain. Reset is asynchronous, active-high.
- Reset values: all outputs registered; every VALID/READY 0; credits = BUF_BEATS; drop_cnt = 0; credit_err = 0; FSM in IDLE; latched notification cleared.
- IDLE:
  - s_axis_notifications_TREADY = 1 (registered; high only in IDLE).
  - On VALID&READY: latch TDATA; go to EVAL next cycle.
- EVAL (1 cycle):
  - len = latched[31:16].
  - beats = (len+63)>>6, 11-bit unsigned, no overflow for len ≤ 65535.
  - Drop if len==0, or len>MAX_LEN, or (ALIGN_ONLY and len[5:0]!=0), or beats>BUF_BEATS.
  - Drop: drop_cnt += 1, saturating at all-ones; go to IDLE.
  - Otherwise go to WAIT_CREDIT.
- WAIT_CREDIT:
  - When credits ≥ beats, go to ISSUE.
  - Both output VALIDs rise on the same cycle the FSM enters ISSUE.
- ISSUE:
  - read_package and meta are held VALID with stable TDATA.
  - Per-channel done flags: each VALID deasserts the cycle after its own handshake.
  - Leave for IDLE once both handshakes have completed, whether on the same cycle or on different cycles.
- Credit debit: credits -= beats on the cycle the read_package handshake completes.
- Credit return: credit_ret adds 1 on any cycle, in any state.
- Same-cycle debit and return: credits_next = credits - beats + credit_ret.
- Return at full: a credit_ret with credits == BUF_BEATS and no debit leaves credits unchanged and sets credit_err.
- Latency: notification accept to both VALIDs high is 3 cycles (IDLE→EVAL→WAIT→ISSUE) when credit is already sufficient.
- Throughput: minimum 4 cycles per message.
- Ordering and backpressure:
  - No reordering: one message in flight through the FSM.
  - Outputs never drop data under backpressure.
  - TDATA is stable while VALID is high.
- Reset mid-operation: any state returns to IDLE immediately. Pending VALIDs drop and the latched message is discarded. Credits restore to BUF_BEATS.
- credits output: reflects the registered count, one cycle after the update.

Test Plan:
- Reset, then send len=128 session=5 with both READYs high → read_package TDATA=0x00800005 and meta copy valid 3 cycles after accept; credits 32→30.
- len=0, then len=4160, then len=100 (ALIGN_ONLY=1) → no outputs; drop_cnt=3; TREADY returns high 2 cycles after each accept.
- credits=2 with len=256 pending → stays in WAIT_CREDIT; two credit_ret pulses give credits=4; ISSUE next cycle; credits then 0.
- meta_TREADY low for 5 cycles while read_package accepted at once → read_package VALID for 1 cycle; meta VALID held 6 cycles with stable data; next notification accepted only after the meta handshake.
- credit_ret asserted on the same cycle as a len=64 debit at credits=10 → credits=10. Then credit_ret with credits=32 → credits stays 32 and credit_err=1 (sticky).
- Assert rst during ISSUE with VALIDs high → VALIDs drop asynchronously; credits=32; drop_cnt=0; first notification after release is processed normally.

Source files
------------

// File: rtl/rx_read_scheduler.sv
// -----------------------------------------------------------------------------
// rx_read_scheduler
//
// Credit-based scheduler between the TCP stack notification stream and the
// read-package request channel. A notification is accepted, evaluated, and
// only turned into a read request once the downstream payload buffer has
// room for the whole message (counted in 64-byte beats). A copy of the
// notification is forwarded as metadata to the merge stage together with the
// read request. Zero-length, oversize and (optionally) unaligned messages are
// dropped and counted.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   s_axis_notifications_*         88-bit notification in
//                                  [15:0] session, [31:16] length (bytes),
//                                  [87:32] opaque
//   m_axis_read_package_*          32-bit read request {length, session}
//   m_axis_meta_*                  88-bit copy of the notification
//   credit_ret                     one pulse per beat drained from the buffer
//   credits                        current free beats
//   drop_cnt                       dropped notifications, saturating
//   credit_err                     sticky; a return arrived while full
//   dbg_state                      FSM state (0 IDLE, 1 EVAL, 2 WAIT, 3 ISSUE)
//
// Handshake rule on every stream: a transfer happens on a rising clock edge
// where VALID and READY are both high. A source never lowers VALID and never
// changes TDATA until that transfer has happened.
// -----------------------------------------------------------------------------
module rx_read_scheduler #(
  parameter int BUF_BEATS  = 32,
  parameter int MAX_LEN    = 4096,
  parameter int ALIGN_ONLY = 1,
  parameter int CNT_W      = 32,
  localparam int CRW       = $clog2(BUF_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [87:0]      s_axis_notifications_TDATA,
  input  logic             s_axis_notifications_TVALID,
  output logic             s_axis_notifications_TREADY,
  output logic [31:0]      m_axis_read_package_TDATA,
  output logic             m_axis_read_package_TVALID,
  input  logic             m_axis_read_package_TREADY,
  output logic [87:0]      m_axis_meta_TDATA,
  output logic             m_axis_meta_TVALID,
  input  logic             m_axis_meta_TREADY,
  input  logic             credit_ret,
  output logic [CRW-1:0]   credits,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             credit_err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  localparam logic [16:0]    MAX_LEN_L   = 17'(MAX_LEN);
  localparam logic [11:0]    BUF_BEATS_W = 12'(BUF_BEATS);
  localparam logic [CRW-1:0] BUF_BEATS_C = CRW'(BUF_BEATS);

  state_t           r_state;
  state_t           w_state_next;
  logic [87:0]      r_notif;
  logic [CRW-1:0]   r_beats;
  logic [CRW-1:0]   r_credits;
  logic [CRW-1:0]   w_credits_next;
  logic             r_credit_err;
  logic             w_credit_err_next;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_tready;
  logic             w_tready_next;
  logic             r_rp_valid;
  logic             w_rp_valid_next;
  logic             r_meta_valid;
  logic             w_meta_valid_next;
  logic             w_load;
  logic             w_drop_inc;

  logic [15:0]      w_len;
  logic [10:0]      w_beats;
  logic             w_drop;
  logic             w_rp_hs;
  logic             w_meta_hs;

  // ---------------------------------------------------------------------------
  // Message evaluation from the latched notification
  // ---------------------------------------------------------------------------
  assign w_len   = r_notif[31:16];
  // 17-bit sum keeps (len + 63) exact for any 16-bit length.
  assign w_beats = 11'(({1'b0, w_len} + 17'd63) >> 6);

  assign w_drop = (w_len == 16'd0)
               || ({1'b0, w_len} > MAX_LEN_L)
               || ((ALIGN_ONLY != 0) && (w_len[5:0] != 6'd0))
               || ({1'b0, w_beats} > BUF_BEATS_W);

  assign w_rp_hs   = r_rp_valid   & m_axis_read_package_TREADY;
  assign w_meta_hs = r_meta_valid & m_axis_meta_TREADY;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and next values of the registered handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_rp_valid_next   = r_rp_valid;
    w_meta_valid_next = r_meta_valid;
    w_load            = 1'b0;
    w_drop_inc        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (s_axis_notifications_TVALID && r_tready) begin
          w_load       = 1'b1;
          w_state_next = ST_EVAL;
        end
      end

      ST_EVAL: begin
        if (w_drop) begin
          w_drop_inc   = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Both VALIDs rise together on entry to ISSUE.
        if (r_credits >= r_beats) begin
          w_state_next      = ST_ISSUE;
          w_rp_valid_next   = 1'b1;
          w_meta_valid_next = 1'b1;
        end
      end

      ST_ISSUE: begin
        // Each channel retires independently; leave once neither is pending.
        if (w_rp_hs) begin
          w_rp_valid_next = 1'b0;
        end
        if (w_meta_hs) begin
          w_meta_valid_next = 1'b0;
        end
        if ((!r_rp_valid || w_rp_hs) && (!r_meta_valid || w_meta_hs)) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // TREADY is registered, so it is derived from where the FSM is heading.
    w_tready_next = (w_state_next == ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Credit accounting
  // ---------------------------------------------------------------------------
  always_comb begin
    w_credits_next    = r_credits;
    w_credit_err_next = r_credit_err;
    if (w_rp_hs) begin
      // beats >= 1 on any issued message, so adding a return cannot overflow.
      w_credits_next = r_credits - r_beats + {{(CRW-1){1'b0}}, credit_ret};
    end else if (credit_ret) begin
      if (r_credits == BUF_BEATS_C) begin
        w_credit_err_next = 1'b1;
      end else begin
        w_credits_next = r_credits + {{(CRW-1){1'b0}}, 1'b1};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_notif      <= '0;
      r_beats      <= '0;
      r_credits    <= BUF_BEATS_C;
      r_credit_err <= 1'b0;
      r_drop_cnt   <= '0;
      r_tready     <= 1'b0;
      r_rp_valid   <= 1'b0;
      r_meta_valid <= 1'b0;
    end else begin
      r_tready     <= w_tready_next;
      r_rp_valid   <= w_rp_valid_next;
      r_meta_valid <= w_meta_valid_next;
      r_credits    <= w_credits_next;
      r_credit_err <= w_credit_err_next;
      if (w_load) begin
        r_notif <= s_axis_notifications_TDATA;
      end
      // Only meaningful when the message passes evaluation, where the beat
      // count is known to fit in the credit width.
      if (r_state == ST_EVAL) begin
        r_beats <= CRW'(w_beats);
      end
      if (w_drop_inc && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign s_axis_notifications_TREADY = r_tready;
  assign m_axis_read_package_TDATA   = r_notif[31:0];
  assign m_axis_read_package_TVALID  = r_rp_valid;
  assign m_axis_meta_TDATA           = r_notif;
  assign m_axis_meta_TVALID          = r_meta_valid;
  assign credits                     = r_credits;
  assign drop_cnt                    = r_drop_cnt;
  assign credit_err                  = r_credit_err;
  assign dbg_state                   = r_state;

endmodule

// File: tb/tb_rx_read_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rx_read_scheduler
//
// Directed bench for rx_read_scheduler with default parameters
// (BUF_BEATS=32, MAX_LEN=4096, ALIGN_ONLY=1, CNT_W=32). Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_rx_read_scheduler;

  localparam logic [55:0] OPQ = 56'h0123456789ABCD;

  logic        clk;
  logic        rst;
  logic [87:0] notif_data;
  logic        notif_valid;
  logic        notif_ready;
  logic [31:0] rp_data;
  logic        rp_valid;
  logic        rp_ready;
  logic [87:0] meta_data;
  logic        meta_valid;
  logic        meta_ready;
  logic        credit_ret;
  logic [5:0]  credits;
  logic [31:0] drop_cnt;
  logic        credit_err;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  rx_read_scheduler dut (
    .clk                         (clk),
    .rst                         (rst),
    .s_axis_notifications_TDATA  (notif_data),
    .s_axis_notifications_TVALID (notif_valid),
    .s_axis_notifications_TREADY (notif_ready),
    .m_axis_read_package_TDATA   (rp_data),
    .m_axis_read_package_TVALID  (rp_valid),
    .m_axis_read_package_TREADY  (rp_ready),
    .m_axis_meta_TDATA           (meta_data),
    .m_axis_meta_TVALID          (meta_valid),
    .m_axis_meta_TREADY          (meta_ready),
    .credit_ret                  (credit_ret),
    .credits                     (credits),
    .drop_cnt                    (drop_cnt),
    .credit_err                  (credit_err),
    .dbg_state                   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  // Presents one notification and returns 1 time unit after the accepting edge.
  task automatic send_notif(input logic [15:0] len, input logic [15:0] sess, input bit issued);
    int n;
    n = 0;
    @(negedge clk);
    notif_data  = {OPQ, len, sess};
    notif_valid = 1'b1;
    while (!notif_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_in_time", notif_ready, 1'b1);
    @(posedge clk);
    #1;
    notif_valid = 1'b0;
    if (issued) exp_q.push_back({len, sess});
  endtask

  // Holds credit_ret high across n rising edges; returns on a falling edge.
  task automatic ret_pulses(input int n);
    @(negedge clk);
    credit_ret = 1'b1;
    repeat (n) @(negedge clk);
    credit_ret = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] drop_lens[3];
    logic [31:0] exp_rp;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    notif_data  = '0;
    notif_valid = 1'b0;
    rp_ready    = 1'b0;
    meta_ready  = 1'b0;
    credit_ret  = 1'b0;
    drop_lens   = '{16'd0, 16'd4160, 16'd100};

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_tready", notif_ready, 1'b0);
    check_eq("rst_rp_valid", rp_valid, 1'b0);
    check_eq("rst_meta_valid", meta_valid, 1'b0);
    check_eq("rst_credits", credits, 6'd32);
    check_eq("rst_drop_cnt", drop_cnt, 32'd0);
    check_eq("rst_credit_err", credit_err, 1'b0);
    check_eq("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_tready", notif_ready, 1'b1);

    // Basic issue: len=128, session 5, three cycles to VALID
    rp_ready   = 1'b1;
    meta_ready = 1'b1;
    send_notif(16'd128, 16'd5, 1'b1);
    @(negedge clk);
    check_eq("t1_eval_no_valid", rp_valid, 1'b0);
    @(negedge clk);
    check_eq("t1_wait_no_valid", rp_valid, 1'b0);
    @(negedge clk);
    check_eq("t1_rp_valid", rp_valid, 1'b1);
    check_eq("t1_meta_valid", meta_valid, 1'b1);
    exp_rp = exp_q.pop_front();
    check_eq("t1_rp_data", rp_data, exp_rp);
    check_eq("t1_rp_data_const", rp_data, 32'h0080_0005);
    check_eq("t1_meta_data", meta_data, {OPQ, 16'h0080, 16'h0005});
    @(negedge clk);
    check_eq("t1_rp_done", rp_valid, 1'b0);
    check_eq("t1_meta_done", meta_valid, 1'b0);
    check_eq("t1_credits", credits, 6'd30);
    check_eq("t1_tready", notif_ready, 1'b1);

    // Drops: zero length, oversize, unaligned
    foreach (drop_lens[i]) begin
      send_notif(drop_lens[i], 16'd7, 1'b0);
      @(negedge clk);
      check_eq("drop_tready_low", notif_ready, 1'b0);
      @(negedge clk);
      check_eq("drop_tready_back", notif_ready, 1'b1);
      check_eq("drop_no_rp", rp_valid, 1'b0);
      check_eq("drop_no_meta", meta_valid, 1'b0);
    end
    check_eq("drop_cnt3", drop_cnt, 32'd3);
    check_eq("drop_credits", credits, 6'd30);

    // Credit wait: bring credits to 2, then a 4-beat message must wait
    send_notif(16'd1792, 16'd1, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("t3_big_valid", rp_valid, 1'b1);
    exp_rp = exp_q.pop_front();
    check_eq("t3_big_data", rp_data, exp_rp);
    @(negedge clk);
    check_eq("t3_credits2", credits, 6'd2);
    send_notif(16'd256, 16'd2, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("t3_in_wait", dbg_state, 2'd2);
    check_eq("t3_no_valid", rp_valid, 1'b0);
    ret_pulses(2);
    check_eq("t3_credits4", credits, 6'd4);
    check_eq("t3_still_wait", rp_valid, 1'b0);
    @(negedge clk);
    check_eq("t3_issue_valid", rp_valid, 1'b1);
    exp_rp = exp_q.pop_front();
    check_eq("t3_issue_data", rp_data, exp_rp);
    @(negedge clk);
    check_eq("t3_credits0", credits, 6'd0);
    check_eq("t3_idle", dbg_state, 2'd0);
    ret_pulses(32);
    check_eq("t3_refill", credits, 6'd32);
    check_eq("t3_no_err", credit_err, 1'b0);

    // Metadata backpressure for 5 cycles, read request accepted at once
    rp_ready   = 1'b1;
    meta_ready = 1'b0;
    send_notif(16'd64, 16'd7, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("t4_rp_valid", rp_valid, 1'b1);
    check_eq("t4_meta_valid", meta_valid, 1'b1);
    exp_rp = exp_q.pop_front();
    check_eq("t4_rp_data", rp_data, exp_rp);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_eq("t4_rp_gone", rp_valid, 1'b0);
      check_eq("t4_meta_held", meta_valid, 1'b1);
      check_eq("t4_meta_stable", meta_data, {OPQ, 16'h0040, 16'h0007});
      check_eq("t4_tready_low", notif_ready, 1'b0);
    end
    meta_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_meta_done", meta_valid, 1'b0);
    check_eq("t4_tready_back", notif_ready, 1'b1);
    check_eq("t4_credits", credits, 6'd31);

    // Same-cycle debit and return, then return while full
    send_notif(16'd1344, 16'd3, 1'b1);
    repeat (3) @(negedge clk);
    exp_rp = exp_q.pop_front();
    check_eq("t5_pre_data", rp_data, exp_rp);
    @(negedge clk);
    check_eq("t5_credits10", credits, 6'd10);
    send_notif(16'd64, 16'd4, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("t5_valid", rp_valid, 1'b1);
    exp_rp = exp_q.pop_front();
    check_eq("t5_data", rp_data, exp_rp);
    credit_ret = 1'b1;
    @(negedge clk);
    credit_ret = 1'b0;
    check_eq("t5_debit_ret", credits, 6'd10);
    check_eq("t5_rp_done", rp_valid, 1'b0);
    ret_pulses(22);
    check_eq("t5_full", credits, 6'd32);
    check_eq("t5_no_err", credit_err, 1'b0);
    ret_pulses(1);
    check_eq("t5_full_stays", credits, 6'd32);
    check_eq("t5_err_set", credit_err, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("t5_err_sticky", credit_err, 1'b1);

    // Reset while in ISSUE
    send_notif(16'd64, 16'd6, 1'b1);
    repeat (3) @(negedge clk);
    exp_rp = exp_q.pop_front();
    check_eq("t6_pre_data", rp_data, exp_rp);
    @(negedge clk);
    check_eq("t6_credits31", credits, 6'd31);
    rp_ready   = 1'b0;
    meta_ready = 1'b0;
    send_notif(16'd128, 16'd2, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("t6_issue_valid", rp_valid, 1'b1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_eq("t6_rst_rp_valid", rp_valid, 1'b0);
    check_eq("t6_rst_meta_valid", meta_valid, 1'b0);
    check_eq("t6_rst_credits", credits, 6'd32);
    check_eq("t6_rst_drop_cnt", drop_cnt, 32'd0);
    check_eq("t6_rst_err", credit_err, 1'b0);
    check_eq("t6_rst_state", dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_tready", notif_ready, 1'b1);
    rp_ready   = 1'b1;
    meta_ready = 1'b1;
    send_notif(16'd128, 16'd9, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("t6_post_valid", rp_valid, 1'b1);
    exp_rp = exp_q.pop_front();
    check_eq("t6_post_data", rp_data, exp_rp);
    check_eq("t6_post_data_const", rp_data, 32'h0080_0009);
    check_eq("t6_post_meta", meta_data, {OPQ, 16'h0080, 16'h0009});
    @(negedge clk);
    check_eq("t6_post_credits", credits, 6'd30);
    check_eq("t6_post_drop_cnt", drop_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
